// File: rtl/seq_shift_add_mult_if.sv
// Operand/product handshake bundle for the shift-add multiplier.
// Master drives operands and out_ready; slave is the multiplier.
interface seq_shift_add_mult_if #(
    parameter int WIDTH = 32,
    parameter int CW    = $clog2(WIDTH + 1)
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_a;
    logic [WIDTH-1:0]     in_b;
    logic                 in_signed;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   out_product;
    logic [CW-1:0]        out_cycles;

    modport master (
        output in_valid,
        output in_a,
        output in_b,
        output in_signed,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_product,
        input  out_cycles
    );

    modport slave (
        input  in_valid,
        input  in_a,
        input  in_b,
        input  in_signed,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_product,
        output out_cycles
    );
endinterface

// File: rtl/seq_shift_add_mult.sv
// Sequential shift-and-add multiplier, one multiplier bit per clock.
// Signed mode works on magnitudes and negates the result at the end.
module seq_shift_add_mult #(
    parameter int WIDTH      = 32,
    parameter int EARLY_EXIT = 0,
    parameter int CW         = $clog2(WIDTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    seq_shift_add_mult_if.slave   bus
);

    localparam int PW = 2 * WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [PW-1:0]    acc_q;
    logic [PW-1:0]    mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [CW-1:0]    cnt_q;
    logic             neg_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [PW-1:0]    prod_q;
    logic [CW-1:0]    cyc_q;

    logic [WIDTH-1:0] amag_d;
    logic [WIDTH-1:0] bmag_d;
    logic             neg_d;
    logic [PW-1:0]    acc_d;
    logic [PW-1:0]    mcand_d;
    logic [WIDTH-1:0] mplier_d;
    logic [CW-1:0]    cnt_d;
    logic             last_d;
    logic [PW-1:0]    prod_d;
    logic             accept_d;

    // Operand magnitudes and result sign taken at capture time.
    // Negating the most-negative value yields 2^(WIDTH-1), which
    // is still correct when read back as an unsigned magnitude.
    always_comb begin
        amag_d = bus.in_a;
        bmag_d = bus.in_b;
        neg_d  = 1'b0;
        if (bus.in_signed) begin
            if (bus.in_a[WIDTH-1]) amag_d = -bus.in_a;
            if (bus.in_b[WIDTH-1]) bmag_d = -bus.in_b;
            neg_d = bus.in_a[WIDTH-1] ^ bus.in_b[WIDTH-1];
        end
    end

    // One shift-add iteration and its termination test.
    // The shifted multiplier is what early exit looks at, so b=0
    // still spends exactly one cycle in MUL.
    always_comb begin
        acc_d    = mplier_q[0] ? acc_q + mcand_q : acc_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        last_d   = (cnt_d == CW'(WIDTH));
        if (EARLY_EXIT != 0 && mplier_d == '0) last_d = 1'b1;
        prod_d   = neg_q ? -acc_d : acc_d;
    end

    assign accept_d = bus.in_valid & in_ready_q;

    // Control FSM, datapath registers and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            cnt_q       <= '0;
            neg_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            prod_q      <= '0;
            cyc_q       <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept_d) begin
                        acc_q      <= '0;
                        mcand_q    <= PW'(amag_d);
                        mplier_q   <= bmag_d;
                        cnt_q      <= '0;
                        neg_q      <= neg_d;
                        in_ready_q <= 1'b0;
                        state_q    <= MUL;
                    end
                end
                MUL: begin
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_d;
                    mplier_q <= mplier_d;
                    cnt_q    <= cnt_d;
                    if (last_d) begin
                        prod_q      <= prod_d;
                        cyc_q       <= cnt_d;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_product = prod_q;
    assign bus.out_cycles  = cyc_q;

endmodule

// File: tb/tb_seq_shift_add_mult.sv
// Directed bench for seq_shift_add_mult, WIDTH=8.
// u0 runs full-length iterations, u1 uses early exit.
module tb_seq_shift_add_mult;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    seq_shift_add_mult_if #(.WIDTH(8)) b0 ();
    seq_shift_add_mult_if #(.WIDTH(8)) b1 ();

    seq_shift_add_mult #(.WIDTH(8), .EARLY_EXIT(0)) u0 (
        .clk (clk),
        .rst (rst),
        .bus (b0)
    );

    seq_shift_add_mult #(.WIDTH(8), .EARLY_EXIT(1)) u1 (
        .clk (clk),
        .rst (rst),
        .bus (b1)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    function automatic logic rdy(input bit s);
        return s ? b1.in_ready : b0.in_ready;
    endfunction

    function automatic logic vld(input bit s);
        return s ? b1.out_valid : b0.out_valid;
    endfunction

    function automatic logic [15:0] prod(input bit s);
        return s ? b1.out_product : b0.out_product;
    endfunction

    function automatic logic [3:0] cyc(input bit s);
        return s ? b1.out_cycles : b0.out_cycles;
    endfunction

    task automatic drive(input bit s, input logic v, input logic [7:0] a,
                         input logic [7:0] b, input logic sg);
        if (s) begin
            b1.in_valid = v; b1.in_a = a; b1.in_b = b; b1.in_signed = sg;
        end else begin
            b0.in_valid = v; b0.in_a = a; b0.in_b = b; b0.in_signed = sg;
        end
    endtask

    // Wait for in_ready, present one operand pair, then count edges
    // (accept edge included) until out_valid is seen. Returns at the
    // negedge where out_valid is high; caller decides on out_ready.
    task automatic run(input string tag, input bit s, input logic [7:0] a,
                       input logic [7:0] b, input logic sg,
                       input logic [15:0] ep, input int ecyc,
                       input int elat);
        int  lat;
        int  w;
        bit  seen;
        w = 0;
        @(negedge clk);
        while (!rdy(s) && w < 50) begin
            @(negedge clk);
            w++;
        end
        check({tag, "_rdy"}, 64'(rdy(s)), 64'd1);
        drive(s, 1'b1, a, b, sg);
        @(posedge clk);
        lat = 1;
        #1 drive(s, 1'b0, ~a, ~b, ~sg);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (vld(s)) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk);
            lat++;
        end
        check({tag, "_vld"}, 64'(seen), 64'd1);
        check({tag, "_prod"}, 64'(prod(s)), 64'(ep));
        check({tag, "_cyc"}, 64'(cyc(s)), 64'(ecyc));
        check({tag, "_lat"}, 64'(lat), 64'(elat));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] hp;
        logic [3:0]  hc;
        rst = 1'b1;
        drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        drive(1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
        b0.out_ready = 1'b1;
        b1.out_ready = 1'b1;
        #12;
        check("rst_rdy", 64'(b0.in_ready), 64'd1);
        check("rst_vld", 64'(b0.out_valid), 64'd0);
        check("rst_prod", 64'(b0.out_product), 64'd0);
        check("rst_cyc", 64'(b0.out_cycles), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        run("u3x5",   1'b0, 8'd3,  8'd5,  1'b0, 16'd15,   8, 9);
        run("s80x80", 1'b0, 8'h80, 8'h80, 1'b1, 16'h4000, 8, 9);
        run("sFDx5",  1'b0, 8'hFD, 8'd5,  1'b1, 16'hFFF1, 8, 9);
        run("uFDx5",  1'b0, 8'hFD, 8'd5,  1'b0, 16'h04F1, 8, 9);
        run("s80x7F", 1'b0, 8'h80, 8'h7F, 1'b1, 16'hC080, 8, 9);
        run("uFFxFF", 1'b0, 8'hFF, 8'hFF, 1'b0, 16'hFE01, 8, 9);
        run("u2x5",   1'b0, 8'd2,  8'd5,  1'b0, 16'd10,   8, 9);

        run("ee_b1",  1'b1, 8'h55, 8'h01, 1'b0, 16'h0055, 1, 2);
        run("ee_b0",  1'b1, 8'h33, 8'h00, 1'b0, 16'h0000, 1, 2);
        run("ee_b80", 1'b1, 8'd3,  8'h80, 1'b0, 16'h0180, 8, 9);
        run("ee_sm1", 1'b1, 8'd5,  8'hFF, 1'b1, 16'hFFFB, 1, 2);
        run("ee_b06", 1'b1, 8'd7,  8'h06, 1'b0, 16'd42,   3, 4);

        b0.out_ready = 1'b0;
        run("bp",     1'b0, 8'h0B, 8'h0D, 1'b0, 16'h008F, 8, 9);
        hp = b0.out_product;
        hc = b0.out_cycles;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_vld", 64'(b0.out_valid), 64'd1);
            check("bp_hold_p", 64'(b0.out_product), 64'h008F);
            check("bp_hold_c", 64'(b0.out_cycles), 64'd8);
            check("bp_rdy", 64'(b0.in_ready), 64'd0);
        end
        check("bp_same_p", 64'(b0.out_product), 64'(hp));
        check("bp_same_c", 64'(b0.out_cycles), 64'(hc));
        b0.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("rel_rdy", 64'(b0.in_ready), 64'd1);
        check("rel_vld", 64'(b0.out_valid), 64'd0);
        run("b2b_7x6", 1'b0, 8'd7, 8'd6, 1'b0, 16'd42, 8, 9);

        @(negedge clk);
        @(negedge clk);
        check("ab_rdy0", 64'(b0.in_ready), 64'd1);
        drive(1'b0, 1'b1, 8'hAB, 8'hCD, 1'b0);
        @(posedge clk);
        #1 drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("ab_vld", 64'(b0.out_valid), 64'd0);
        check("ab_prod", 64'(b0.out_product), 64'd0);
        check("ab_rdy", 64'(b0.in_ready), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        run("post_9x9", 1'b0, 8'd9, 8'd9, 1'b0, 16'd81, 8, 9);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
